inst_fetch_stage: RTL and testbench

//  Pipeline IF stage. Owns the PC, drives the instruction-ROM address, and registers the returned word into the IF/ID register.

---
 rtl/inst_fetch_stage_pkg.sv | 13 +
 rtl/inst_fetch_stage_npc_select.sv | 23 ++
 rtl/inst_fetch_stage.sv | 51 +++++
 tb/tb_inst_fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_stage_pkg.sv
// inst_fetch_stage_pkg: shared vectors, bubble word and next-PC selection codes for the IF stage.
package inst_fetch_stage_pkg;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [4:0]  K0_IDX    = 5'd26;
  typedef enum logic [2:0] {SEL_SEQ, SEL_HOLD, SEL_REDIR, SEL_IRQ, SEL_EXC} npc_sel_e;
  // Increment never touches the kernel flag; carry out of bit 30 is dropped.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction
endpackage

// File: rtl/inst_fetch_stage_npc_select.sv
// npc_select: priority mux for the next PC with kernel-bit masking of non-jr redirects.
module npc_select
  import inst_fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_jr,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] npc,
  output npc_sel_e    sel
);
  logic        irq_ok;
  logic [31:0] tgt;
  always_comb begin
    irq_ok = irq & ~pc[31] & ~stall & ~redirect;
    tgt    = redirect_jr ? redirect_pc : {pc[31], redirect_pc[30:0]};
    sel    = exc ? SEL_EXC : irq_ok ? SEL_IRQ : redirect ? SEL_REDIR : stall ? SEL_HOLD : SEL_SEQ;
    npc    = exc ? XADR_VEC : irq_ok ? ILLOP_VEC : redirect ? tgt : stall ? pc : pc_inc(pc);
  end
endmodule

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: owns the PC, addresses the instruction ROM and registers the fetched word into IF/ID.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_jr,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        epc_we,
  output logic [31:0] epc
);
  logic [31:0] pc;
  logic [31:0] npc;
  npc_sel_e    sel;
  assign imem_addr = pc;
  npc_select u_npc (
    .pc(pc), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .redirect_jr(redirect_jr), .irq(irq), .exc(exc), .npc(npc), .sel(sel)
  );
  // Every non-hold, non-sequential choice squashes IF/ID into a bubble with pc4 kept.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc          <= RESET_VEC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      epc_we      <= 1'b0;
      epc         <= '0;
    end else begin
      epc_we <= sel == SEL_IRQ;
      if (sel == SEL_IRQ) epc <= pc;
      if (sel != SEL_HOLD) pc <= npc;
      if (sel == SEL_SEQ) begin
        if_id_instr <= imem_data;
        if_id_pc4   <= npc;
        if_id_valid <= 1'b1;
      end else if (sel != SEL_HOLD) begin
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb_inst_fetch_stage: directed scenarios plus randomized traffic against a rule-level model of the IF stage.
module tb_inst_fetch_stage;
  logic        clk = 0;
  logic        reset = 0;
  logic [31:0] imem_addr, imem_data, redirect_pc = 0;
  logic        stall = 0, redirect = 0, redirect_jr = 0, irq = 0, exc = 0;
  logic [31:0] if_id_instr, if_id_pc4, epc;
  logic        if_id_valid, epc_we;
  int          n_checks = 0, n_fail = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_epc_we;

  inst_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .redirect_jr(redirect_jr),
    .irq(irq), .exc(exc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .epc_we(epc_we), .epc(epc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[8:2], a[8:2], a[8:2], a[8:2], 4'ha};
  endfunction
  assign imem_data = rom(imem_addr);

  // Reference: the per-edge priority rules written out directly.
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_pc <= 32'h8000_0000; m_instr <= 0; m_pc4 <= 0; m_valid <= 0; m_epc_we <= 0; m_epc <= 0;
    end else if (exc) begin
      m_pc <= 32'h8000_0008; m_instr <= 0; m_valid <= 0; m_epc_we <= 0;
    end else if (irq && !m_pc[31] && !stall && !redirect) begin
      m_pc <= 32'h8000_0004; m_instr <= 0; m_valid <= 0; m_epc_we <= 1; m_epc <= m_pc;
    end else if (redirect) begin
      m_pc <= redirect_jr ? redirect_pc : {m_pc[31], redirect_pc[30:0]};
      m_instr <= 0; m_valid <= 0; m_epc_we <= 0;
    end else if (stall) begin
      m_epc_we <= 0;
    end else begin
      m_pc <= {m_pc[31], m_pc[30:0] + 31'd4};
      m_pc4 <= {m_pc[31], m_pc[30:0] + 31'd4};
      m_instr <= rom(m_pc); m_valid <= 1; m_epc_we <= 0;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      chk("model.addr", imem_addr, m_pc);
      chk("model.instr", if_id_instr, m_instr);
      chk("model.pc4", if_id_pc4, m_pc4);
      chk("model.valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      chk("model.epc_we", {31'd0, epc_we}, {31'd0, m_epc_we});
      chk("model.epc", epc, m_epc);
    end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    stall = 0; redirect = 0; redirect_jr = 0; redirect_pc = 0; irq = 0; exc = 0;
  endtask

  task automatic redir(input logic [31:0] t, input logic jr);
    redirect = 1; redirect_jr = jr; redirect_pc = t;
    cyc();
    clr();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst.addr", imem_addr, 32'h8000_0000);
    chk("rst.valid", {31'd0, if_id_valid}, 0);
    chk("rst.pc4", if_id_pc4, 0);
    chk("rst.epc", epc, 0);
    cyc();
    chk("seq.addr1", imem_addr, 32'h8000_0004);
    chk("seq.instr1", if_id_instr, 32'h0000_000a);
    chk("seq.pc4_1", if_id_pc4, 32'h8000_0004);
    chk("seq.valid1", {31'd0, if_id_valid}, 1);
    cyc();
    chk("seq.addr2", imem_addr, 32'h8000_0008);
    redir(32'h0000_00b4, 0);
    chk("kredir.addr", imem_addr, 32'h8000_00b4);
    redir(32'h0000_0000, 1);
    chk("jr.addr", imem_addr, 32'h0000_0000);
    chk("jr.valid", {31'd0, if_id_valid}, 0);
    repeat (4) cyc();
    chk("pre_stall.addr", imem_addr, 32'h0000_0010);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall.addr", imem_addr, 32'h0000_0010);
      chk("stall.pc4", if_id_pc4, 32'h0000_0010);
      chk("stall.instr", if_id_instr, rom(32'h0000_000c));
    end
    stall = 0;
    cyc();
    chk("resume.addr", imem_addr, 32'h0000_0014);
    chk("resume.instr", if_id_instr, rom(32'h0000_0010));
    chk("resume.pc4", if_id_pc4, 32'h0000_0014);
    repeat (11) cyc();
    chk("pre_br.addr", imem_addr, 32'h0000_0040);
    redir(32'h8000_0100, 0);
    chk("br_mask.addr", imem_addr, 32'h0000_0100);
    chk("br_mask.valid", {31'd0, if_id_valid}, 0);
    redir(32'h0000_0078, 0);
    irq = 1;
    cyc();
    chk("irq.addr", imem_addr, 32'h8000_0004);
    chk("irq.epc_we", {31'd0, epc_we}, 1);
    chk("irq.epc", epc, 32'h0000_0078);
    cyc();
    chk("irq_k.addr", imem_addr, 32'h8000_0008);
    chk("irq_k.epc_we", {31'd0, epc_we}, 0);
    clr();
    redir(32'h0000_0020, 1);
    exc = 1; irq = 1;
    cyc();
    clr();
    chk("exc.addr", imem_addr, 32'h8000_0008);
    chk("exc.epc_we", {31'd0, epc_we}, 0);
    chk("exc.valid", {31'd0, if_id_valid}, 0);
    chk("exc.epc", epc, 32'h0000_0078);
    redir(32'h0000_0200, 1);
    stall = 1;
    redir(32'h0000_0300, 0);
    chk("redir_stall.addr", imem_addr, 32'h0000_0300);
    stall = 1; redirect = 1; redirect_pc = 32'h0000_0400;
    #2 reset = 0;
    #1;
    chk("arst.addr", imem_addr, 32'h8000_0000);
    chk("arst.valid", {31'd0, if_id_valid}, 0);
    chk("arst.epc", epc, 0);
    @(negedge clk);
    clr();
    reset = 1;
    for (int i = 0; i < 3000; i++) begin
      stall = $urandom_range(0, 4) == 0;
      redirect = $urandom_range(0, 6) == 0;
      redirect_jr = $urandom_range(0, 1) == 1;
      redirect_pc = $urandom & 32'h8000_01fc;
      if ($urandom_range(0, 9) == 0) irq = ~irq;
      exc = $urandom_range(0, 30) == 0;
      cyc();
    end
    clr();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
